// File: rtl/uart_rx_ctrl.sv
// UART receive controller: start detection, oversampled majority-vote bit sampling,
// deserializer steering, parity/stop checking and one-cycle frame status pulses.
module uart_rx_ctrl #(
  parameter int DATA_BITS = 8
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       RX_IN,
  input  logic [5:0] prescale,
  input  logic       PAR_EN,
  input  logic       PAR_TYP,
  output logic       deser_en,
  output logic [5:0] edge_cnt,
  output logic       sampled_bit,
  output logic       data_valid,
  output logic       par_err,
  output logic       stp_err,
  output logic       busy
);

  localparam int CNT_W = $clog2(DATA_BITS + 1);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_BITS - 1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_PARITY = 3'd3,
    S_STOP   = 3'd4
  } state_t;

  state_t           state_q, state_d;
  logic [5:0]       edge_q, edge_d;
  logic [5:0]       presc_q, presc_d;
  logic             par_en_q, par_en_d;
  logic             par_typ_q, par_typ_d;
  logic             s0_q, s0_d;
  logic             s1_q, s1_d;
  logic             smp_q, smp_d;
  logic [CNT_W-1:0] bit_cnt_q, bit_cnt_d;
  logic             par_q, par_d;
  logic             mism_q, mism_d;
  logic             dv_q, dv_d;
  logic             pe_q, pe_d;
  logic             se_q, se_d;

  logic             end_bit_s;
  logic [5:0]       half_s;

  function automatic logic maj3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

  function automatic logic parity_expected(input logic running, input logic odd);
    return running ^ odd;
  endfunction

  assign half_s    = {1'b0, presc_q[5:1]};
  assign end_bit_s = (edge_q == (presc_q - 6'd1));

  // Next-state logic: edge counter, mid-bit sampling and frame sequencing
  always_comb begin
    state_d   = state_q;
    edge_d    = edge_q;
    presc_d   = presc_q;
    par_en_d  = par_en_q;
    par_typ_d = par_typ_q;
    s0_d      = s0_q;
    s1_d      = s1_q;
    smp_d     = smp_q;
    bit_cnt_d = bit_cnt_q;
    par_d     = par_q;
    mism_d    = mism_q;
    dv_d      = 1'b0;
    pe_d      = 1'b0;
    se_d      = 1'b0;

    if (state_q == S_IDLE) begin
      edge_d = 6'd0;
    end else if (end_bit_s) begin
      edge_d = 6'd0;
    end else begin
      edge_d = edge_q + 6'd1;
    end

    // Three samples centred on mid-bit; the vote lands one edge after the centre
    if (state_q == S_IDLE) begin
      smp_d = smp_q;
    end else if (edge_q == (half_s - 6'd1)) begin
      s0_d = RX_IN;
    end else if (edge_q == half_s) begin
      s1_d = RX_IN;
    end else if (edge_q == (half_s + 6'd1)) begin
      smp_d = maj3(s0_q, s1_q, RX_IN);
    end else begin
      smp_d = smp_q;
    end

    case (state_q)
      S_IDLE: begin
        if (!RX_IN) begin
          state_d   = S_START;
          edge_d    = 6'd1;
          presc_d   = prescale;
          par_en_d  = PAR_EN;
          par_typ_d = PAR_TYP;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_START: begin
        if (end_bit_s) begin
          if (!smp_q) begin
            state_d   = S_DATA;
            bit_cnt_d = '0;
            par_d     = 1'b0;
            mism_d    = 1'b0;
          end else begin
            state_d = S_IDLE;
          end
        end else begin
          state_d = S_START;
        end
      end
      S_DATA: begin
        if (end_bit_s) begin
          par_d     = par_q ^ smp_q;
          bit_cnt_d = bit_cnt_q + 1'b1;
          if (bit_cnt_q == LAST_BIT) begin
            state_d = par_en_q ? S_PARITY : S_STOP;
          end else begin
            state_d = S_DATA;
          end
        end else begin
          state_d = S_DATA;
        end
      end
      S_PARITY: begin
        if (end_bit_s) begin
          mism_d  = (smp_q != parity_expected(par_q, par_typ_q));
          state_d = S_STOP;
        end else begin
          state_d = S_PARITY;
        end
      end
      S_STOP: begin
        if (end_bit_s) begin
          state_d = S_IDLE;
          se_d    = ~smp_q;
          pe_d    = mism_q;
          dv_d    = smp_q & ~mism_q;
        end else begin
          state_d = S_STOP;
        end
      end
      default: begin
        state_d = S_IDLE;
        edge_d  = 6'd0;
      end
    endcase
  end

  // State and datapath registers with asynchronous active-low reset
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q   <= S_IDLE;
      edge_q    <= 6'd0;
      presc_q   <= 6'd8;
      par_en_q  <= 1'b0;
      par_typ_q <= 1'b0;
      s0_q      <= 1'b1;
      s1_q      <= 1'b1;
      smp_q     <= 1'b1;
      bit_cnt_q <= '0;
      par_q     <= 1'b0;
      mism_q    <= 1'b0;
      dv_q      <= 1'b0;
      pe_q      <= 1'b0;
      se_q      <= 1'b0;
    end else begin
      state_q   <= state_d;
      edge_q    <= edge_d;
      presc_q   <= presc_d;
      par_en_q  <= par_en_d;
      par_typ_q <= par_typ_d;
      s0_q      <= s0_d;
      s1_q      <= s1_d;
      smp_q     <= smp_d;
      bit_cnt_q <= bit_cnt_d;
      par_q     <= par_d;
      mism_q    <= mism_d;
      dv_q      <= dv_d;
      pe_q      <= pe_d;
      se_q      <= se_d;
    end
  end

  assign deser_en    = (state_q == S_DATA);
  assign busy        = (state_q != S_IDLE);
  assign edge_cnt    = edge_q;
  assign sampled_bit = smp_q;
  assign data_valid  = dv_q;
  assign par_err     = pe_q;
  assign stp_err     = se_q;

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Scoreboard bench for uart_rx_ctrl: directed frames push expected status pulses,
// a negedge monitor pops and compares them together with a model deserializer.
module tb_uart_rx_ctrl;

  logic       CLK = 1'b0;
  logic       RST = 1'b0;
  logic       RX_IN = 1'b1;
  logic [5:0] prescale = 6'd8;
  logic       PAR_EN = 1'b0;
  logic       PAR_TYP = 1'b0;
  logic       deser_en;
  logic [5:0] edge_cnt;
  logic       sampled_bit;
  logic       data_valid;
  logic       par_err;
  logic       stp_err;
  logic       busy;

  uart_rx_ctrl #(.DATA_BITS(8)) dut (
    .CLK(CLK), .RST(RST), .RX_IN(RX_IN), .prescale(prescale),
    .PAR_EN(PAR_EN), .PAR_TYP(PAR_TYP), .deser_en(deser_en),
    .edge_cnt(edge_cnt), .sampled_bit(sampled_bit), .data_valid(data_valid),
    .par_err(par_err), .stp_err(stp_err), .busy(busy)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic [2:0] kind;   // {data_valid, par_err, stp_err}
    int         cyc;
    logic [7:0] data;
  } exp_t;

  exp_t       sb_q[$];
  int         checks = 0;
  int         errors = 0;
  int         cyc = 0;
  logic [7:0] p_data = 8'd0;
  int         de_first = -1;
  int         de_last = -1;
  logic       de_seen = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  always @(posedge CLK) cyc <= cyc + 1;

  // Model 8-bit deserializer: latches sampled_bit at each data end-of-bit, LSB first
  always @(posedge CLK) begin
    if (deser_en && edge_cnt == prescale - 6'd1) p_data <= {sampled_bit, p_data[7:1]};
  end

  // Monitor: deser_en window tracking and scoreboard comparison of status pulses
  always @(negedge CLK) begin
    if (RST && deser_en) begin
      de_seen = 1'b1;
      if (de_first < 0) de_first = cyc;
      de_last = cyc;
    end
    if (RST && (data_valid || par_err || stp_err)) begin
      if (sb_q.size() == 0) begin
        chk("unexpected_pulse", 32'({data_valid, par_err, stp_err}), 32'd0);
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        chk("pulse_kind", 32'({data_valid, par_err, stp_err}), 32'(e.kind));
        chk("pulse_cycle", 32'(cyc), 32'(e.cyc));
        if (data_valid) chk("p_data", 32'(p_data), 32'(e.data));
      end
    end
  end

  // Drive one frame; inv_edge >= 0 inverts data bits at that edge; abort_at >= 0 resets there
  task automatic send_frame(input logic [7:0] d, input int p, input logic pen, input logic ptyp,
                            input logic pbit, input logic sbit, input logic [2:0] exp_kind,
                            input int inv_edge, input int abort_at, output int t0);
    logic bits[11];
    int   nb;
    int   idx;
    bits[0] = 1'b0;
    for (int i = 0; i < 8; i++) bits[i+1] = d[i];
    nb = pen ? 11 : 10;
    if (pen) bits[9] = pbit;
    bits[nb-1] = sbit;
    prescale = 6'(p);
    PAR_EN   = pen;
    PAR_TYP  = ptyp;
    t0  = 0;
    idx = 0;
    for (int b = 0; b < nb; b++) begin
      for (int k = 0; k < p; k++) begin
        @(posedge CLK); #1;
        if (idx == 0) begin
          t0 = cyc;
          if (abort_at < 0) begin
            exp_t e;
            e.kind = exp_kind;
            e.cyc  = t0 + nb * p;
            e.data = d;
            sb_q.push_back(e);
          end
        end
        if (idx == abort_at) begin
          RST = 1'b0;
          RX_IN = 1'b1;
          #1;
          chk("abort_busy", 32'(busy), 32'd0);
          chk("abort_deser_en", 32'(deser_en), 32'd0);
          chk("abort_edge_cnt", 32'(edge_cnt), 32'd0);
          chk("abort_sampled_bit", 32'(sampled_bit), 32'd1);
          chk("abort_pulses", 32'({data_valid, par_err, stp_err}), 32'd0);
          return;
        end
        RX_IN = (b >= 1 && b <= 8 && k == inv_edge) ? ~bits[b] : bits[b];
        idx++;
      end
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge CLK); #1;
      RX_IN = 1'b1;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int t0;
    repeat (3) @(posedge CLK);
    @(negedge CLK);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_edge_cnt", 32'(edge_cnt), 32'd0);
    chk("rst_sampled_bit", 32'(sampled_bit), 32'd1);
    chk("rst_deser_en", 32'(deser_en), 32'd0);
    chk("rst_pulses", 32'({data_valid, par_err, stp_err}), 32'd0);
    RST = 1'b1;
    idle(4);

    // 0xA5, P=8, even parity, correct parity bit 0
    de_first = -1;
    send_frame(8'hA5, 8, 1'b1, 1'b0, 1'b0, 1'b1, 3'b100, -1, -1, t0);
    chk("deser_en_first", 32'(de_first), 32'(t0 + 8));
    chk("deser_en_last", 32'(de_last), 32'(t0 + 71));
    idle(5);

    // Odd parity expected, parity bit 0 -> parity error
    send_frame(8'hA5, 8, 1'b1, 1'b1, 1'b0, 1'b1, 3'b010, -1, -1, t0);
    idle(5);

    // P=16, no parity, stop bit 0 -> stop error at T0+160
    send_frame(8'h3C, 16, 1'b0, 1'b0, 1'b0, 1'b0, 3'b001, -1, -1, t0);
    idle(5);

    // Start glitch: two low cycles only
    prescale = 6'd8;
    PAR_EN   = 1'b0;
    de_seen  = 1'b0;
    for (int k = 0; k < 14; k++) begin
      @(posedge CLK); #1;
      if (k == 0) t0 = cyc;
      RX_IN = (k < 2) ? 1'b0 : 1'b1;
      if (k == 7) begin
        @(negedge CLK);
        chk("glitch_sampled_bit", 32'(sampled_bit), 32'd1);
        chk("glitch_busy_end_start", 32'(busy), 32'd1);
        chk("glitch_edge_cnt", 32'(edge_cnt), 32'd7);
      end
      if (k == 8) begin
        @(negedge CLK);
        chk("glitch_idle", 32'(busy), 32'd0);
      end
    end
    chk("glitch_no_deser_en", 32'(de_seen), 32'd0);

    // Majority vote: data bits inverted at edge 3
    send_frame(8'h5A, 8, 1'b1, 1'b0, 1'b0, 1'b1, 3'b100, 3, -1, t0);
    idle(3);

    // P=32, odd parity, correct parity bit 0
    send_frame(8'h01, 32, 1'b1, 1'b1, 1'b0, 1'b1, 3'b100, -1, -1, t0);
    idle(3);

    // Back-to-back frames, second aborted by reset mid-data
    send_frame(8'hC3, 8, 1'b0, 1'b0, 1'b0, 1'b1, 3'b100, -1, -1, t0);
    send_frame(8'h99, 8, 1'b0, 1'b0, 1'b0, 1'b1, 3'b000, -1, 36, t0);
    idle(3);
    RST = 1'b1;
    idle(4);

    // Clean frame after reset
    send_frame(8'h7E, 8, 1'b1, 1'b0, 1'b0, 1'b1, 3'b100, -1, -1, t0);
    idle(10);

    chk("scoreboard_drained", 32'(sb_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_rx_ctrl.md
Name: uart_rx_ctrl

Overview:
- Receive-side controller and bit sampler for the UART RX path.
- Detects the start bit on a synchronized RX_IN line, maintains the oversampling edge counter, and majority-votes each bit.
- Steers the deserializer via deser_en, edge_cnt and sampled_bit; checks parity and stop bits; flags a completed frame.
- Sits directly upstream of the 8-bit deserializer. Its outputs connect 1:1 to the deserializer inputs of the same names.

Parameters:
- DATA_BITS, 8, data bits per frame (LSB first); the deserializer is fixed at 8.

Ports:
- CLK  in  1  clock
- RST  in  1  asynchronous reset, active-low
- RX_IN  in  1  serial line, already synchronized to CLK; idle high
- prescale  in  6  oversampling ratio; supported values: even, 6..62 (8/16/32 in use)
- PAR_EN  in  1  1 = frame carries a parity bit
- PAR_TYP  in  1  0 = even parity, 1 = odd parity
- deser_en  out  1  high for the whole DATA state
- edge_cnt  out  6  oversample edge index within the current bit, 0..prescale-1
- sampled_bit  out  1  majority-voted value of the current bit
- data_valid  out  1  one-cycle pulse for an error-free frame
- par_err  out  1  one-cycle pulse: parity mismatch
- stp_err  out  1  one-cycle pulse: stop bit sampled 0
- busy  out  1  high in every state except IDLE

Behaviour:
- Reset values: state IDLE; edge_cnt 0; sampled_bit 1; deser_en, data_valid, par_err, stp_err, busy all 0; internal bit counter 0; running parity 0.
- Reset asserted mid-frame aborts immediately to these values. No pulse is produced for the aborted frame.
- Configuration latch: prescale, PAR_EN and PAR_TYP are captured on the IDLE->START transition. Changes during a frame take effect on the next frame.
- Let P = latched prescale and H = P/2. "End of bit" means the cycle with edge_cnt == P-1.
- Edge counter: increments every cycle outside IDLE and wraps P-1 -> 0. In IDLE it holds 0.
- Sampling: capture RX_IN at edge_cnt H-1 and at H. At edge_cnt H+1, register sampled_bit = majority(s0, s1, RX_IN). sampled_bit holds until the next update and is stable at end of bit.
- IDLE:
  - RX_IN == 0 -> START.
  - The detection cycle counts as edge 0, so edge_cnt <= 1.
- START, at end of bit:
  - sampled_bit == 0 -> DATA, bit counter 0, running parity 0.
  - sampled_bit == 1 -> IDLE (glitch; no error flag).
- DATA:
  - deser_en = 1 combinationally from the state.
  - At each end of bit: running parity ^= sampled_bit and the bit counter increments.
  - At end of bit with counter == DATA_BITS-1: go to PARITY if PAR_EN, else STOP.
  - The deserializer latches each bit at this same end-of-bit cycle.
- PARITY, at end of bit:
  - expected = running parity ^ PAR_TYP.
  - Record mismatch = (sampled_bit != expected); go to STOP.
- STOP, at end of bit:
  - Go to IDLE.
  - Next cycle: stp_err = !sampled_bit; par_err = recorded mismatch; data_valid = !(stp_err | par_err).
  - All three are registered and pulse for exactly one cycle.
- Back-to-back frames: a start edge in the cycle right after the stop bit ends is detected in IDLE. There is no dead time.
- Latency: with T0 = the start-detection cycle and N = 10 (no parity) or 11 (parity), data_valid is asserted at T0 + N*P.
- P_DATA is stable when data_valid is seen: the last data bit was latched at least P cycles earlier.

Test Plan:
- P=8, PAR_EN=1, PAR_TYP=0, frame 0xA5 (data bits 1,0,1,0,0,1,0,1; parity 0; stop 1), start detected at T0:
  - deser_en high T0+8..T0+71.
  - data_valid pulses at T0+88; par_err = stp_err = 0.
  - Downstream P_DATA = 0xA5.
- Same frame with PAR_TYP=1 and parity bit 0:
  - par_err pulse at T0+88; data_valid stays 0.
- P=16, PAR_EN=0, frame 0x3C with stop bit driven 0:
  - stp_err pulse at T0+160; data_valid 0.
- Start glitch: RX_IN low for 2 cycles only, P=8:
  - sampled_bit = 1 at end of start bit; return to IDLE at T0+8.
  - No pulses; deser_en never asserted.
- Majority vote: P=8; in every data bit, force RX_IN inverted at edge 3 only:
  - Frame still decodes correctly; data_valid asserted.
- Two frames back-to-back, then RST pulled low mid-way through the second frame's data:
  - First frame gives data_valid.
  - On reset, all outputs return to reset values immediately.
  - No pulse for the second frame; the next clean frame decodes normally.
